// File: rtl/core_inst_sequencer.sv
// rtl/core_inst_sequencer.sv - core instruction word sequencer for one conv layer tile
// Runs 9 kij passes (weight/activation load, execute, psum write-back) then 16 output-pixel accumulations.
module core_inst_sequencer #(
  parameter int          col     = 8,
  parameter int          row     = 8,
  parameter int          len_nij = 36,
  parameter int          in_w    = 6,
  parameter int          out_w   = 4,
  parameter int          ksize   = 3,
  parameter int unsigned WBASE   = 11'h400,
  parameter int          ADDR_W  = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode,
  input  logic        ofifo_valid,
  output logic [34:0] inst,
  output logic        sfp_clr,
  output logic        busy,
  output logic        done,
  output logic [3:0]  kij_o
);

  localparam int LEN_KIJ  = ksize * ksize;
  localparam int LEN_ONIJ = out_w * out_w;
  localparam int EXEC_LEN = len_nij + row + col;
  localparam int CW       = 8;
  localparam logic [34:0] IDLE_INST = 35'h1800C0000;

  typedef enum logic [3:0] {
    S_IDLE, S_WL0, S_WLOAD, S_XL0, S_EXEC, S_PWR, S_GAP, S_ACC, S_DONE
  } state_t;

  state_t          state, ret, nxt_state, nxt_ret;
  logic [CW-1:0]   cnt, nxt_cnt, n_done, kk;
  logic [CW-1:0]   onij, nxt_onij;
  logic [3:0]      kij, nxt_kij;
  logic            mode_q, nxt_mode, wr_q, nxt_wr;
  logic [34:0]     nxt_inst;
  logic            nxt_sfp, nxt_busy, nxt_done;
  logic [ADDR_W-1:0] a_x, a_p;

  // Next-cycle state is computed here and the instruction word is decoded
  // from it, so every output lands in a register on the same edge.
  always_comb begin
    nxt_state = state;
    nxt_ret   = ret;
    nxt_cnt   = cnt;
    nxt_kij   = kij;
    nxt_onij  = onij;
    nxt_mode  = mode_q;
    nxt_wr    = 1'b0;
    n_done    = cnt + CW'(wr_q);
    unique case (state)
      S_IDLE: if (start) begin
        nxt_state = S_WL0;
        nxt_cnt   = '0;
        nxt_kij   = '0;
        nxt_onij  = '0;
        nxt_mode  = mode;
      end
      S_WL0:   if (cnt == CW'(col - 1)) begin nxt_state = S_GAP; nxt_ret = S_WLOAD; end
               else nxt_cnt = cnt + 1'b1;
      S_WLOAD: if (cnt == CW'(col - 1)) begin nxt_state = S_GAP; nxt_ret = S_XL0; end
               else nxt_cnt = cnt + 1'b1;
      S_XL0:   if (cnt == CW'(len_nij - 1)) begin nxt_state = S_GAP; nxt_ret = S_EXEC; end
               else nxt_cnt = cnt + 1'b1;
      S_EXEC:  if (cnt == CW'(EXEC_LEN - 1)) begin nxt_state = S_GAP; nxt_ret = S_PWR; end
               else nxt_cnt = cnt + 1'b1;
      // cnt holds the index of the write in flight; it only advances on cycles that issued one
      S_PWR: if (n_done == CW'(len_nij)) begin
        nxt_state = S_GAP;
        nxt_ret   = (kij == 4'(LEN_KIJ - 1)) ? S_ACC : S_WL0;
      end else begin
        nxt_cnt = n_done;
        nxt_wr  = ofifo_valid;
      end
      S_GAP: begin
        nxt_state = ret;
        nxt_cnt   = '0;
        if (ret == S_WL0) nxt_kij = kij + 1'b1;
        if (ret == S_PWR) nxt_wr = ofifo_valid;
        if (ret == S_ACC) nxt_onij = '0;
      end
      S_ACC: if (cnt == CW'(11)) begin
        if (onij == CW'(LEN_ONIJ - 1)) nxt_state = S_DONE;
        else begin
          nxt_onij = onij + 1'b1;
          nxt_cnt  = '0;
        end
      end else nxt_cnt = cnt + 1'b1;
      S_DONE: begin
        nxt_state = S_IDLE;
        nxt_kij   = '0;
      end
      default: nxt_state = S_IDLE;
    endcase

    kk  = nxt_cnt - 1'b1;
    a_x = ADDR_W'(WBASE) + ADDR_W'(nxt_kij) * (ADDR_W'(col) << nxt_mode) + ADDR_W'(nxt_cnt);
    a_p = ADDR_W'(kk) * ADDR_W'(len_nij)
        + (ADDR_W'(nxt_onij) / ADDR_W'(out_w) + ADDR_W'(kk) / ADDR_W'(ksize)) * ADDR_W'(in_w)
        + ADDR_W'(nxt_onij) % ADDR_W'(out_w) + ADDR_W'(kk) % ADDR_W'(ksize);

    nxt_inst = IDLE_INST;
    nxt_sfp  = 1'b0;
    nxt_done = (nxt_state == S_DONE);
    nxt_busy = (nxt_state != S_IDLE) && (nxt_state != S_DONE);
    if (nxt_state != S_IDLE) nxt_inst[34] = nxt_mode;
    unique case (nxt_state)
      S_WL0: begin
        nxt_inst[19]   = 1'b0;
        nxt_inst[2]    = 1'b1;
        nxt_inst[17:7] = a_x;
      end
      S_WLOAD: begin
        nxt_inst[3] = 1'b1;
        nxt_inst[0] = 1'b1;
      end
      S_XL0: begin
        nxt_inst[19]   = 1'b0;
        nxt_inst[2]    = 1'b1;
        nxt_inst[17:7] = ADDR_W'(nxt_cnt);
      end
      S_EXEC: begin
        nxt_inst[3] = 1'b1;
        nxt_inst[1] = 1'b1;
      end
      S_PWR: if (nxt_wr) begin
        nxt_inst[6]     = 1'b1;
        nxt_inst[32]    = 1'b0;
        nxt_inst[31]    = 1'b0;
        nxt_inst[30:20] = ADDR_W'(nxt_kij) * ADDR_W'(len_nij) + ADDR_W'(nxt_cnt);
      end
      // acc trails the pmem read by one cycle, matching the read latency
      S_ACC: begin
        if (nxt_cnt == '0) nxt_sfp = 1'b1;
        if (nxt_cnt >= CW'(1) && nxt_cnt <= CW'(9)) begin
          nxt_inst[32]    = 1'b0;
          nxt_inst[30:20] = a_p;
        end
        if (nxt_cnt >= CW'(2) && nxt_cnt <= CW'(10)) nxt_inst[33] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      ret     <= S_IDLE;
      cnt     <= '0;
      kij     <= '0;
      onij    <= '0;
      mode_q  <= 1'b0;
      wr_q    <= 1'b0;
      inst    <= IDLE_INST;
      sfp_clr <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= nxt_state;
      ret     <= nxt_ret;
      cnt     <= nxt_cnt;
      kij     <= nxt_kij;
      onij    <= nxt_onij;
      mode_q  <= nxt_mode;
      wr_q    <= nxt_wr;
      inst    <= nxt_inst;
      sfp_clr <= nxt_sfp;
      busy    <= nxt_busy;
      done    <= nxt_done;
    end
  end

  assign kij_o = kij;

endmodule

// File: tb/tb_core_inst_sequencer.sv
// tb/tb_core_inst_sequencer.sv - directed self-checking bench for core_inst_sequencer
module tb_core_inst_sequencer;
  localparam logic [34:0] IDLE_INST = 35'h1800C0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic        ofifo_valid = 1'b1;
  logic [34:0] inst;
  logic        sfp_clr, busy, done;
  logic [3:0]  kij_o;
  int          tests = 0;
  int          fails = 0;

  core_inst_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .ofifo_valid(ofifo_valid),
    .inst(inst), .sfp_clr(sfp_clr), .busy(busy), .done(done), .kij_o(kij_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic m);
    start = 1'b1;
    mode  = m;
    tick();
    start = 1'b0;
  endtask

  task automatic run_seq(input logic m, input bit do_stall, input bit do_inject,
                         input int exp_done, input string nm);
    int t = 0, t_done = -1, kij_prev = 0, n_wr = 0, wr_err = 0, mode_err = 0, kij_err = 0;
    int ff_err = 0, exec0 = 0, sfp_n = 0, rd_px = 0, acc_px = 0, acc_tot = 0, acc_err = 0;
    int rd_err = 0, done_n = 0, stall_left = 0, stall_err = 0, resume = -1, a00 = -1, a54 = -1, a158 = -1;
    int wl0_cnt[9], wl0_first[9], k, o, exp_a;
    bit seen_load[9], stall_done = 0, expect_resume = 0, injected = 0, inj_clear = 0;
    bit rd, wr;
    for (int i = 0; i < 9; i++) begin wl0_cnt[i] = 0; wl0_first[i] = -1; seen_load[i] = 0; end
    ofifo_valid = 1'b1;
    pulse_start(m);
    while (t < 3000) begin
      if (inj_clear) begin start = 1'b0; mode = m; inj_clear = 0; end
      rd = !inst[32] && inst[31];
      wr = !inst[32] && !inst[31];
      if (inst[5] || inst[4]) ff_err++;
      if (busy && inst[34] !== m) mode_err++;
      if (busy && kij_o != 4'(kij_prev)) begin
        if (int'(kij_o) != kij_prev + 1) kij_err++;
        kij_prev = kij_o;
      end
      if (inst[1] && kij_o == 0) exec0++;
      if (kij_o < 9) begin
        if (inst[0]) seen_load[kij_o] = 1;
        if (inst[2] && !seen_load[kij_o]) begin
          if (wl0_cnt[kij_o] == 0) wl0_first[kij_o] = inst[17:7];
          wl0_cnt[kij_o]++;
        end
      end
      if (wr) begin
        if (!inst[6] || int'(inst[30:20]) != n_wr) wr_err++;
        n_wr++;
      end
      if (stall_left > 0) begin
        if (inst[6] || !inst[31]) stall_err++;
        stall_left--;
        if (stall_left == 0) begin ofifo_valid = 1'b1; expect_resume = 1; end
      end else if (expect_resume && wr) begin
        resume = inst[30:20];
        expect_resume = 0;
      end
      if (do_stall && !stall_done && wr && inst[30:20] == 11'd81) begin
        stall_left = 5; ofifo_valid = 1'b0; stall_done = 1;
      end
      if (do_inject && !injected && busy && kij_o == 4) begin
        start = 1'b1; mode = ~m; injected = 1; inj_clear = 1;
      end
      if (sfp_clr) begin
        if (sfp_n > 0 && (rd_px != 9 || acc_px != 9)) acc_err++;
        sfp_n++; rd_px = 0; acc_px = 0;
      end
      if (inst[33]) begin acc_px++; acc_tot++; end
      if (sfp_n > 0 && rd) begin
        o = sfp_n - 1; k = rd_px;
        exp_a = k * 36 + ((o / 4 + k / 3) * 6 + (o % 4 + k % 3));
        if (int'(inst[30:20]) != exp_a) rd_err++;
        if (o == 0 && k == 0) a00 = inst[30:20];
        if (o == 5 && k == 4) a54 = inst[30:20];
        if (o == 15 && k == 8) a158 = inst[30:20];
        rd_px++;
      end
      if (done) begin
        done_n++; t_done = t;
        chk({nm, " busy_at_done"}, 64'(busy), 64'd0);
        break;
      end
      tick();
      t++;
    end
    if (rd_px != 9 || acc_px != 9) acc_err++;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done || busy) done_n++;
    end
    chk({nm, " done_cycle"}, 64'(t_done), 64'(exp_done));
    chk({nm, " done_pulses"}, 64'(done_n), 64'd1);
    chk({nm, " idle_after"}, 64'(inst), 64'(IDLE_INST));
    chk({nm, " mode_bit_err"}, 64'(mode_err), 64'd0);
    chk({nm, " kij_seq_err"}, 64'(kij_err), 64'd0);
    chk({nm, " kij_last"}, 64'(kij_prev), 64'd8);
    chk({nm, " ififo_err"}, 64'(ff_err), 64'd0);
    chk({nm, " pwr_addr_err"}, 64'(wr_err), 64'd0);
    chk({nm, " pwr_count"}, 64'(n_wr), 64'd324);
    chk({nm, " exec_kij0"}, 64'(exec0), 64'd52);
    chk({nm, " wl0_first0"}, 64'(wl0_first[0]), 64'd1024);
    chk({nm, " wl0_first1"}, 64'(wl0_first[1]), m ? 64'd1040 : 64'd1032);
    chk({nm, " wl0_cnt1"}, 64'(wl0_cnt[1]), 64'd8);
    chk({nm, " sfp_pulses"}, 64'(sfp_n), 64'd16);
    chk({nm, " acc_per_px_err"}, 64'(acc_err), 64'd0);
    chk({nm, " acc_total"}, 64'(acc_tot), 64'd144);
    chk({nm, " acc_addr_err"}, 64'(rd_err), 64'd0);
    chk({nm, " acc_a_o0_k0"}, 64'(a00), 64'd0);
    chk({nm, " acc_a_o5_k4"}, 64'(a54), 64'd158);
    chk({nm, " acc_a_o15_k8"}, 64'(a158), 64'd323);
    if (do_stall) begin
      chk({nm, " stall_seen"}, 64'(stall_done), 64'd1);
      chk({nm, " stall_idle_err"}, 64'(stall_err), 64'd0);
      chk({nm, " stall_resume"}, 64'(resume), 64'd82);
    end
  endtask

  initial begin : stim
    int t;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("rst inst", 64'(inst), 64'(IDLE_INST));
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst sfp_clr", 64'(sfp_clr), 64'd0);
    chk("rst kij_o", 64'(kij_o), 64'd0);

    pulse_start(1'b0);
    t = 0;
    while (!(kij_o == 3 && inst[1]) && t < 2000) begin tick(); t++; end
    chk("reach kij3 exec", 64'(t < 2000), 64'd1);
    chk("kij3 exec busy", 64'(busy), 64'd1);
    reset = 1'b0;
    tick();
    chk("abort inst", 64'(inst), 64'(IDLE_INST));
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort kij_o", 64'(kij_o), 64'd0);
    reset = 1'b1;
    tick();
    tick();
    chk("abort stays idle", 64'(inst), 64'(IDLE_INST));

    run_seq(1'b0, 1'b0, 1'b0, 1497, "m0");
    run_seq(1'b1, 1'b1, 1'b1, 1502, "m1");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/core_inst_sequencer.md
Name: core_inst_sequencer

Overview:
Autonomous controller that generates the 35-bit core instruction word. It replaces hand-driven instruction stimulus with a synthesizable FSM that runs one full conv layer tile: 9 kij passes of weight-load, activation-load, execute and psum write-back, then 16 output-pixel accumulations. It sits between the host/top level and core.inst; the host preloads xmem (activations at 0, weights at WBASE) before pulsing start.

Parameters:
col, 8, PE array columns (weight rows loaded per kij)
row, 8, PE array rows
len_nij, 36, input pixels per tile (in_w*in_w)
in_w, 6, input feature-map width
out_w, 4, output feature-map width (len_onij = out_w*out_w = 16)
ksize, 3, kernel width (len_kij = ksize*ksize = 9)
WBASE, 11'h400, xmem base address of kij=0 weights
ADDR_W, 11, xmem/pmem address width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; accepted only in IDLE
mode  in  1  0=4-bit, 1=2-bit; sampled on accepted start
ofifo_valid  in  1  core OFIFO has a full output row
inst  out  35  core instruction word: [34]mode [33]acc [32]CEN_pmem [31]WEN_pmem [30:20]A_pmem [19]CEN_xmem [18]WEN_xmem [17:7]A_xmem [6]ofifo_rd [5]ififo_wr [4]ififo_rd [3]l0_rd [2]l0_wr [1]execute [0]load
sfp_clr  out  1  one-cycle clear of SFP accumulator before each output pixel
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after final accumulation
kij_o  out  4  current kij index (0..8)

Behaviour:
- Idle word IDLE_INST = CEN/WEN bits (32,31,19,18) = 1, all others 0 → 35'h1800C0000; inst[34] holds latched mode during the run and 0 in IDLE.
- Reset (async, active-low): state=IDLE, inst=IDLE_INST, sfp_clr=busy=done=0, kij_o=0, all counters 0. Reset mid-run aborts immediately; no resume.
- All outputs registered; instruction fields change on posedge clk.
- Per-kij phase sequence (one IDLE_INST gap cycle after each phase):
  W_L0: col cycles, CEN_xmem=0, WEN_xmem=1, l0_wr=1, A_xmem = WBASE + kij*(col<<mode) + i.
  W_LOAD: col cycles, l0_rd=1, load=1.
  X_L0: len_nij cycles, CEN_xmem=0, l0_wr=1, A_xmem = i (0..len_nij-1).
  EXEC: len_nij+row+col cycles, l0_rd=1, execute=1.
  P_WR: count len_nij writes; each write cycle asserts ofifo_rd=1, CEN_pmem=0, WEN_pmem=0, A_pmem = kij*len_nij + n; a write issues only in cycles where ofifo_valid=1. Otherwise idle fields are driven and n holds (stall, unbounded).
- After the gap following P_WR: kij<8 → kij+1, go to W_L0; kij=8 → ACC.
- ACC, per onij o=0..15 (12 cycles each):
  c0: sfp_clr=1.
  c1..c9: CEN_pmem=0, WEN_pmem=1, A_pmem = k*len_nij + ((o/out_w + k/ksize)*in_w + (o%out_w + k%ksize)), k=c-1.
  acc=1 on c2..c10; c10 has CEN_pmem=1.
  c11: idle.
- After o=15: one cycle with done=1 and busy=0, then IDLE.
- Nominal run (col=row=8, no stalls): 145 cycles/kij ×9 = 1305, + 192 ACC cycles.
- start while busy is ignored. ififo_wr/ififo_rd are always 0. Address arithmetic is unsigned ADDR_W bits and wraps mod 2^11; default parameters never wrap.

Test Plan:
- Reset low mid-EXEC at kij=3 → next edge inst=35'h1800C0000, busy=0, kij_o=0; later start runs full sequence from kij=0.
- mode=0 start, ofifo_valid tied 1 → kij=0 W_L0 A_xmem 1024..1031; EXEC execute high exactly 52 cycles; P_WR A_pmem 0..35; done at cycle 1305+192 after start; inst[34]=0 throughout.
- mode=1 start → kij=1 W_L0 A_xmem starts 1040 (11'b10000010000), 8 l0_wr cycles; inst[34]=1 for entire run.
- ACC address check → onij=0,kij=0 A_pmem=0; onij=5,kij=4 A_pmem=158; onij=15,kij=8 A_pmem=323; acc high exactly 9 cycles per pixel, sfp_clr 16 pulses total.
- ofifo_valid low for 5 cycles at n=10 of kij=2 P_WR → no ofifo_rd/WEN_pmem=0 during gap, A_pmem resumes at 82, run completes 5 cycles later than nominal.
- start pulsed while busy at kij=4 → ignored, kij_o sequence and done timing unchanged; exactly one done pulse.
